// File: rtl/tank_ctrl.sv
// Per-tank motion/life controller: synchronises buttons and the game tick, steps the tank one
// cell per tick with edge saturation, and tracks alive/dead. Optional respawn: TANK_RESPAWN_EN.
module tank_ctrl #(
  parameter int unsigned GRID_W   = 20,
  parameter int unsigned GRID_H   = 22,
  parameter int unsigned INIT_X   = 10,
  parameter int unsigned INIT_Y   = 20,
  parameter logic [1:0]  INIT_DIR = 2'b00
`ifdef TANK_RESPAWN_EN
  ,
  parameter int unsigned RESPAWN_TICKS = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_4Hz,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  output logic [4:0] x_rel_pos,
  output logic [4:0] y_rel_pos,
  output logic [1:0] tank_dir,
  output logic       tank_state,
  output logic       step
);

  typedef enum logic {
    ST_ALIVE = 1'b0,
    ST_DEAD  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam logic [4:0] X_MAX    = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX    = 5'(GRID_H - 1);
  localparam logic [4:0] X_START  = 5'(INIT_X);
  localparam logic [4:0] Y_START  = 5'(INIT_Y);
  localparam dir_e       DIR_INIT = dir_e'(INIT_DIR);
`ifdef TANK_RESPAWN_EN
  localparam logic [4:0] CNT_LAST = 5'(RESPAWN_TICKS - 1);
`endif

  // ---------------------------------------------------------------------------
  // Input synchronisers and tick edge detect
  // ---------------------------------------------------------------------------
  // tick_sync_q[1] is the synchronised level, tick_sync_q[2] its one-clk delayed copy.
  logic [2:0] tick_sync_q;
  logic [3:0] btn_s1_q;
  logic [3:0] btn_s2_q;
  logic       step_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_sync_q <= '0;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      step_q      <= 1'b0;
    end else begin
      tick_sync_q <= {tick_sync_q[1:0], clk_4Hz};
      btn_s1_q    <= {btn_up, btn_down, btn_left, btn_right};
      btn_s2_q    <= btn_s1_q;
      step_q      <= tick_sync_q[1] & ~tick_sync_q[2];
    end
  end

  // ---------------------------------------------------------------------------
  // Button decode: up > down > left > right
  // ---------------------------------------------------------------------------
  logic btn_any;
  dir_e btn_dir;

  assign btn_any = |btn_s2_q;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    btn_dir = DIR_RIGHT;
    if (btn_s2_q[3]) begin
      btn_dir = DIR_UP;
    end else if (btn_s2_q[2]) begin
      btn_dir = DIR_DOWN;
    end else if (btn_s2_q[1]) begin
      btn_dir = DIR_LEFT;
    end
  end

  // ---------------------------------------------------------------------------
  // Alive/dead FSM with position and direction
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [4:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  dir_e       dir_q, dir_d;
  logic       tank_state_q, tank_state_d;
`ifdef TANK_RESPAWN_EN
  logic [4:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ALIVE;
      x_q          <= X_START;
      y_q          <= Y_START;
      dir_q        <= DIR_INIT;
      tank_state_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      tank_state_q <= tank_state_d;
    end
  end

`ifdef TANK_RESPAWN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
`ifdef TANK_RESPAWN_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_ALIVE: begin
        // A shell hit takes precedence over any coincident move.
        if (hit) begin
          state_d = ST_DEAD;
        end else if (step_q && btn_any) begin
          dir_d = btn_dir;
          unique case (btn_dir)
            DIR_UP:    if (y_q != 5'd0)  y_d = y_q - 5'd1;
            DIR_DOWN:  if (y_q != Y_MAX) y_d = y_q + 5'd1;
            DIR_LEFT:  if (x_q != 5'd0)  x_d = x_q - 5'd1;
            DIR_RIGHT: if (x_q != X_MAX) x_d = x_q + 5'd1;
          endcase
        end
      end
      ST_DEAD: begin
`ifdef TANK_RESPAWN_EN
        if (step_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_ALIVE;
            x_d     = X_START;
            y_d     = Y_START;
            dir_d   = DIR_INIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
`endif
      end
    endcase
    tank_state_d = (state_d == ST_ALIVE);
  end

  assign x_rel_pos  = x_q;
  assign y_rel_pos  = y_q;
  assign tank_dir   = dir_q;
  assign tank_state = tank_state_q;
  assign step       = step_q;

endmodule

// File: tb/tb_tank_ctrl.sv
// Bench for tank_ctrl: directed scenarios with literal expectations plus randomized stimulus,
// all checked every cycle against a cycle-history reference model.
module tb_tank_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_4Hz = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       hit = 1'b0;
  logic [4:0] x_rel_pos, y_rel_pos;
  logic [1:0] tank_dir;
  logic       tank_state, step;

  int n_checks = 0;
  int n_fail   = 0;

  tank_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clk_4Hz    (clk_4Hz),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .hit        (hit),
    .x_rel_pos  (x_rel_pos),
    .y_rel_pos  (y_rel_pos),
    .tank_dir   (tank_dir),
    .tank_state (tank_state),
    .step       (step)
  );

  always #5 clk = ~clk;

  // Reference model. Inputs are sampled at each rising edge; the bench keeps a short history
  // so that a tick seen at edge k produces step after edge k+2 and moves the tank at edge k+3,
  // and a button seen at edge k steers a move at edge k+2.
  logic       m_valid = 1'b0;
  logic [3:0] h_tick;
  logic [3:0] h_btn1, h_btn2;
  int         m_x, m_y, m_dir, m_cnt;
  logic       m_alive, m_step;

  always @(posedge clk) begin
    logic step_used;
    int nx, ny, nd, nc;
    logic na;
    if (rst) begin
      m_valid <= 1'b1;
      h_tick  <= '0;
      h_btn1  <= '0;
      h_btn2  <= '0;
      m_x     <= 10;
      m_y     <= 20;
      m_dir   <= 0;
      m_alive <= 1'b1;
      m_cnt   <= 0;
      m_step  <= 1'b0;
    end else begin
      step_used = h_tick[2] & ~h_tick[3];
      nx = m_x; ny = m_y; nd = m_dir; na = m_alive; nc = m_cnt;
      if (m_alive) begin
        if (hit) begin
          na = 1'b0;
        end else if (step_used && h_btn2 != 4'b0) begin
          if (h_btn2[3])      begin nd = 0; if (ny > 0)  ny = ny - 1; end
          else if (h_btn2[2]) begin nd = 1; if (ny < 21) ny = ny + 1; end
          else if (h_btn2[1]) begin nd = 2; if (nx > 0)  nx = nx - 1; end
          else                begin nd = 3; if (nx < 19) nx = nx + 1; end
        end
      end else begin
`ifdef TANK_RESPAWN_EN
        if (step_used) begin
          if (nc == 7) begin
            na = 1'b1; nx = 10; ny = 20; nd = 0; nc = 0;
          end else begin
            nc = nc + 1;
          end
        end
`endif
      end
      m_x     <= nx;
      m_y     <= ny;
      m_dir   <= nd;
      m_alive <= na;
      m_cnt   <= nc;
      m_step  <= h_tick[1] & ~h_tick[2];
      h_tick  <= {h_tick[2:0], clk_4Hz};
      h_btn1  <= {btn_up, btn_down, btn_left, btn_right};
      h_btn2  <= h_btn1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (x_rel_pos !== 5'(m_x) || y_rel_pos !== 5'(m_y) || tank_dir !== 2'(m_dir) ||
          tank_state !== m_alive || step !== m_step) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got x=%0d y=%0d dir=%0d state=%0b step=%0b, want x=%0d y=%0d dir=%0d state=%0b step=%0b",
                 $time, x_rel_pos, y_rel_pos, tank_dir, tank_state, step,
                 m_x, m_y, m_dir, m_alive, m_step);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic game_tick();
    clk_4Hz = 1'b1;
    wait_clks(6);
    clk_4Hz = 1'b0;
    wait_clks(6);
  endtask

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int d, input int s);
    check({tag, "_x"}, 32'(x_rel_pos), 32'(x));
    check({tag, "_y"}, 32'(y_rel_pos), 32'(y));
    check({tag, "_dir"}, 32'(tank_dir), 32'(d));
    check({tag, "_state"}, 32'(tank_state), 32'(s));
  endtask

  initial begin
    wait_clks(2);
    rst = 1'b0;
    check_pos("reset", 10, 20, 0, 1);
    check("reset_step", 32'(step), 32'd0);

    // Tick-to-step latency and pulse width; a held-high tick gives no further steps.
    wait_clks(2);
    clk_4Hz = 1'b1;
    wait_clks(1); check("step_lat1", 32'(step), 32'd0);
    wait_clks(1); check("step_lat2", 32'(step), 32'd0);
    wait_clks(1); check("step_lat3", 32'(step), 32'd1);
    wait_clks(1); check("step_width", 32'(step), 32'd0);
    wait_clks(10);
    check("step_held", 32'(step), 32'd0);
    clk_4Hz = 1'b0;
    wait_clks(6);
    check_pos("idle_tick", 10, 20, 0, 1);

    set_btn(0, 0, 0, 1);
    repeat (3) game_tick();
    check_pos("right3", 13, 20, 3, 1);

    set_btn(1, 0, 1, 0);
    game_tick();
    check_pos("up_left", 13, 19, 0, 1);

    set_btn(0, 0, 1, 0);
    repeat (15) game_tick();
    check_pos("left_edge", 0, 19, 2, 1);

    set_btn(0, 1, 0, 0);
    repeat (4) game_tick();
    check_pos("down_edge", 0, 21, 1, 1);

    // Hit lands on the same clock as a step with up held: no move.
    set_btn(1, 0, 0, 0);
    wait_clks(4);
    clk_4Hz = 1'b1;
    wait_clks(3);
    check("hit_step_aligned", 32'(step), 32'd1);
    hit = 1'b1;
    wait_clks(1);
    hit = 1'b0;
    check_pos("hit", 0, 21, 1, 0);
    wait_clks(5);
    clk_4Hz = 1'b0;
    wait_clks(6);

`ifdef TANK_RESPAWN_EN
    repeat (7) game_tick();
    check_pos("dead7", 0, 21, 1, 0);
    game_tick();
    check_pos("respawn", 10, 20, 0, 1);
    game_tick();
    check_pos("post_respawn", 10, 19, 0, 1);
    set_btn(0, 0, 0, 0);
    hit = 1'b1; wait_clks(1); hit = 1'b0;
    repeat (3) game_tick();
    clk_4Hz = 1'b1;
    wait_clks(3);
    do_reset();
    check_pos("rst_mid_respawn", 10, 20, 0, 1);
    clk_4Hz = 1'b0;
    wait_clks(6);
`else
    repeat (40) game_tick();
    check_pos("dead40", 0, 21, 1, 0);
    do_reset();
    check_pos("rst_after_dead", 10, 20, 0, 1);
`endif

    // Randomized phase; the every-cycle comparison does the checking.
    set_btn(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        btn_up    = $urandom_range(3) == 0;
        btn_down  = $urandom_range(3) == 0;
        btn_left  = $urandom_range(3) == 0;
        btn_right = $urandom_range(3) == 0;
      end
      if ($urandom_range(4) == 0) clk_4Hz = ~clk_4Hz;
      hit = ($urandom_range(59) == 0);
      rst = ($urandom_range(399) == 0);
      wait_clks(1);
    end
    rst = 1'b0;
    hit = 1'b0;
    wait_clks(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
